mic_spi_sampler: RTL and testbench
==================================

Name: mic_spi_sampler

Overview:
- Microphone A/D front end directly upstream of the AM transmitter's CIC/gain path.
- On each request strobe (the transmitter's audio-rate CE), runs one 16-clock SPI conversion frame on a 12-bit serial ADC (4 leading zeros, then 12 data bits MSB-first).
- Returns a signed 12-bit sample with a one-cycle valid pulse, plus overrun and frame-error flags.

Parameters:
- CKPCK, 2: system clocks per SCK half-period (≥1).
- FRAME_BITS, 16: SCK cycles per conversion frame.
- DATA_BITS, 12: data bits at the end of the frame.
- OPT_SIGNED, 1: 1 = invert the MSB (offset binary to two's complement); 0 = raw.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  enable; low aborts and idles the interface
- i_request  in  1  start-conversion strobe
- o_csn  out  1  ADC chip select, active low
- o_sck  out  1  SPI clock, idles high
- i_miso  in  1  ADC serial data
- o_valid  out  1  one-cycle sample-ready pulse
- o_data  out  DATA_BITS  sample (signed if OPT_SIGNED)
- o_frame_err  out  1  leading bits of the last frame were nonzero; updates with o_valid
- o_overrun  out  1  one-cycle pulse: request arrived while busy
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, o_csn=1, o_sck=1, o_valid=0, o_data=0, o_frame_err=0, o_overrun=0, internal counters 0.
- States:
  - IDLE → SETUP on the edge sampling i_en && i_request.
  - SETUP: CKPCK clocks, csn=0, sck=1.
  - SHIFT: FRAME_BITS SCK periods. Each period is CKPCK clocks sck=0, then CKPCK clocks sck=1.
  - HOLD: CKPCK clocks, csn=1, sck=1.
  - HOLD → IDLE, with o_valid=1 on that same edge.
- Outputs o_csn and o_sck are registered (glitch-free).
- Latency: o_valid is high in the cycle beginning 34·CKPCK clock edges after the sampling edge, i.e. 68 clocks for CKPCK=2 (fits the 72-clock period of 500 kHz at 36 MHz).
- Sampling: i_miso is shifted into a FRAME_BITS shift register, MSB first, on the last system clock of each sck-low half (coincident with the sck rising edge).
- Output on o_valid:
  - o_data = shift[DATA_BITS-1:0], MSB inverted when OPT_SIGNED.
  - o_frame_err = |shift[FRAME_BITS-1:DATA_BITS].
  - o_data and o_frame_err hold until the next o_valid.
- Boundary conditions:
  - i_request while state != IDLE: ignored, o_overrun pulses for 1 cycle, frame unaffected.
  - i_request in the IDLE cycle where o_valid=1: accepted (back-to-back). Maximum rate is one sample per 34·CKPCK+1 clocks.
  - i_en low in any state: next edge → IDLE, csn=1, sck=1, no o_valid, o_data retained; a simultaneous i_request is ignored with no overrun.
  - Reset mid-frame: immediate return to reset values.
- Counters: half-period counter width clog2(CKPCK); bit counter width clog2(FRAME_BITS)+1; no wrap beyond the terminal count.

Decomposition:
- Shared package (sdr_pkg) holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD}
  - default frame constants 16/12
  - ADC leading-zero count constant
- One natural sub-module: spi_half_tick, a CKPCK-divider emitting half-period terminal-count pulses with a sync clear. The top FSM uses it for SETUP, SHIFT and HOLD timing.

Test Plan:
- CKPCK=2, request, ADC model returns 0x0800 (raw 0x800) → o_valid at edge 68; o_data=0x000; o_frame_err=0; exactly 16 sck rising edges while csn=0.
- Raw 0xFFF then 0x000, OPT_SIGNED=1 → o_data=0x7FF, then 0x800 (-2048). With OPT_SIGNED=0 → 0xFFF, 0x000.
- Frame word 0x5ABC → o_data=0x2BC (0xABC with MSB inverted), o_frame_err=1. Next frame 0x0123 → o_frame_err=0.
- Second request 10 clocks after the first → o_overrun single pulse, first sample unaffected. Request on the o_valid cycle → new frame starts, csn low on the next edge.
- i_en dropped at clock 30 of a frame → csn=1 and sck=1 on the next edge, no o_valid, o_data unchanged; re-enable plus request gives a normal frame.
- Assert i_reset_n=0 mid-SHIFT, asynchronously between edges → outputs take reset values immediately. CKPCK=1 and CKPCK=5 runs → latencies of 34 and 170 clocks.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared definitions for the microphone SPI sampler: FSM states and ADC frame geometry.
package sdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_BITS  = 12;
    localparam int ADC_LEAD_ZEROS = DEF_FRAME_BITS - DEF_DATA_BITS;

endpackage

// File: rtl/spi_half_tick.sv
// Divides the system clock by CKPCK and pulses o_tick on the last clock of each SCK half-period.
module spi_half_tick #(
    parameter int CKPCK = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CKPCK > 1) ? $clog2(CKPCK) : 1;

    logic [CW-1:0] count;

    assign o_tick = (count == CW'(CKPCK - 1));

    // Wraps to zero on the terminal count so consecutive phases start aligned.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear || o_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mic_spi_sampler.sv
// Runs one SPI conversion frame on a 12-bit serial ADC per request strobe and
// returns the sample with a valid pulse plus overrun and frame-error flags.
module mic_spi_sampler
    import sdr_pkg::*;
#(
    parameter int CKPCK      = 2,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter bit OPT_SIGNED = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_request,
    output logic                 o_csn,
    output logic                 o_sck,
    input  logic                 i_miso,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int BW = $clog2(FRAME_BITS) + 1;
    localparam logic [DATA_BITS-1:0] SIGN_FLIP = {OPT_SIGNED, {(DATA_BITS-1){1'b0}}};

    state_t                state, state_next;
    logic                  csn_next, sck_next, valid_next, ferr_next, ovr_next;
    logic [FRAME_BITS-1:0] shift, shift_next;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0]  data_next;
    logic                  tick, half_clear;

    assign half_clear = (state == IDLE) || !i_en;
    assign o_busy     = (state != IDLE);

    spi_half_tick #(.CKPCK(CKPCK)) u_half_tick (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (half_clear),
        .o_tick    (tick)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            o_csn       <= 1'b1;
            o_sck       <= 1'b1;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
        end else begin
            state       <= state_next;
            o_csn       <= csn_next;
            o_sck       <= sck_next;
            o_valid     <= valid_next;
            o_data      <= data_next;
            o_frame_err <= ferr_next;
            o_overrun   <= ovr_next;
            shift       <= shift_next;
            bit_cnt     <= bit_cnt_next;
        end
    end

    // A request is only an overrun when enabled; disabling silently drops everything.
    always_comb begin
        state_next   = state;
        csn_next     = o_csn;
        sck_next     = o_sck;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        valid_next   = 1'b0;
        data_next    = o_data;
        ferr_next    = o_frame_err;
        ovr_next     = 1'b0;

        if (!i_en) begin
            state_next = IDLE;
            csn_next   = 1'b1;
            sck_next   = 1'b1;
        end else begin
            ovr_next = i_request && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_request) begin
                        state_next   = SETUP;
                        csn_next     = 1'b0;
                        sck_next     = 1'b1;
                        bit_cnt_next = '0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_next = SHIFT;
                        sck_next   = 1'b0;
                    end
                end
                SHIFT: begin
                    // MISO is captured on the clock that raises SCK.
                    if (tick) begin
                        if (!o_sck) begin
                            sck_next     = 1'b1;
                            shift_next   = {shift[FRAME_BITS-2:0], i_miso};
                            bit_cnt_next = bit_cnt + 1'b1;
                        end else if (bit_cnt == BW'(FRAME_BITS)) begin
                            state_next = HOLD;
                            csn_next   = 1'b1;
                        end else begin
                            sck_next = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_next = IDLE;
                        valid_next = 1'b1;
                        data_next  = shift[DATA_BITS-1:0] ^ SIGN_FLIP;
                        ferr_next  = |shift[FRAME_BITS-1:DATA_BITS];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_spi_sampler.sv
// Scoreboard bench for mic_spi_sampler: three instances (CKPCK 2/1/5) driven by an
// ADC model, expected samples computed from the frame word and queued per request.
module tb_mic_spi_sampler;

    typedef struct {
        logic [1:0] id;
        int         data;
        int         ferr;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  req;
    logic [2:0]  csn, sck, miso, valid, ferr, ovr, busy;
    logic [11:0] dat [3];
    logic [15:0] adc_word [3];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   free_cyc [3];
    int   last_data [3];
    int   rises_a = 0;
    int   rises_base_a = 0;
    exp_t expq [$];
    int   ovrq [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    mic_spi_sampler #(.CKPCK(2), .OPT_SIGNED(1'b1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_request(req[0]),
        .o_csn(csn[0]), .o_sck(sck[0]), .i_miso(miso[0]), .o_valid(valid[0]),
        .o_data(dat[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(busy[0])
    );

    mic_spi_sampler #(.CKPCK(1), .OPT_SIGNED(1'b0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_request(req[1]),
        .o_csn(csn[1]), .o_sck(sck[1]), .i_miso(miso[1]), .o_valid(valid[1]),
        .o_data(dat[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(busy[1])
    );

    mic_spi_sampler #(.CKPCK(5), .OPT_SIGNED(1'b1)) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_request(req[2]),
        .o_csn(csn[2]), .o_sck(sck[2]), .i_miso(miso[2]), .o_valid(valid[2]),
        .o_data(dat[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(busy[2])
    );

    function automatic int ck_of(input logic [1:0] k);
        case (k)
            2'd0:    return 2;
            2'd1:    return 1;
            default: return 5;
        endcase
    endfunction

    // Reference: ADC word -> sample value as an integer, offset binary shifted by half scale.
    function automatic int model_data(input logic [1:0] k, input int word);
        int raw;
        raw = word % 4096;
        if (k == 2'd1) return raw;
        return (raw + 4096 - 2048) % 4096;
    endfunction

    function automatic int model_ferr(input int word);
        return ((word / 4096) != 0) ? 1 : 0;
    endfunction

    function automatic logic miso_bit(input logic [15:0] w, input int n);
        logic [15:0] t;
        if (n < 1 || n > 16) return 1'b0;
        t = w >> (16 - n);
        return t[0];
    endfunction

    // ADC model: a new bit appears after each SCK fall while selected, MSB first.
    for (genvar g = 0; g < 3; g++) begin : adc
        int nfall = 0;
        always @(negedge sck[g] or posedge csn[g]) begin
            if (csn[g]) nfall = 0;
            else        nfall = nfall + 1;
        end
        assign miso[g] = miso_bit(adc_word[g], nfall);
    end

    always @(posedge sck[0]) if (!csn[0]) rises_a = rises_a + 1;
    always @(negedge csn[0]) rises_base_a = rises_a;

    task automatic check_output(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Called at a falling edge; the request is sampled on the following rising edge.
    task automatic apply_stimulus(input logic [1:0] k, input int word);
        exp_t e;
        adc_word[k] = 16'(word);
        req[k]      = 1'b1;
        e.id   = k;
        e.data = model_data(k, word);
        e.ferr = model_ferr(word);
        e.cyc  = cyc + 1 + 34 * ck_of(k);
        expq.push_back(e);
        free_cyc[k] = e.cyc;
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) check_output("drain timeout", expq.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_free(input logic [1:0] k);
        int n;
        n = 0;
        while (cyc < free_cyc[k] && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: pops the matching expectation whenever an instance presents a sample.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) last_data[k] = 0;
            end
            for (logic [1:0] k = 0; k < 3; k++) begin
                if (valid[k]) begin
                    int   found;
                    exp_t e;
                    found = -1;
                    for (int j = 0; j < expq.size(); j++) begin
                        if (found < 0 && expq[j].id == k) found = j;
                    end
                    if (found < 0) begin
                        check_output("stray valid", int'(valid[k]), 0);
                    end else begin
                        e = expq[found];
                        expq.delete(found);
                        check_output("latency", cyc, e.cyc);
                        check_output("data", int'(dat[k]), e.data);
                        check_output("frame_err", int'(ferr[k]), e.ferr);
                        if (k == 2'd0) check_output("sck rises", rises_a - rises_base_a, 16);
                        last_data[k] = e.data;
                    end
                end
            end
            for (int j = expq.size() - 1; j >= 0; j--) begin
                if (cyc > expq[j].cyc) begin
                    check_output("missing valid", cyc, expq[j].cyc);
                    expq.delete(j);
                end
            end
            if (ovr[0]) begin
                if (ovrq.size() == 0) check_output("stray overrun", int'(ovr[0]), 0);
                else                  check_output("overrun cycle", cyc, ovrq.pop_front());
            end
            if (ovrq.size() != 0 && cyc > ovrq[0]) begin
                check_output("missing overrun", cyc, ovrq[0]);
                void'(ovrq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            adc_word[k] = 16'h0000;
            free_cyc[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (logic [1:0] k = 0; k < 3; k++) begin
            check_output("reset csn", int'(csn[k]), 1);
            check_output("reset sck", int'(sck[k]), 1);
            check_output("reset valid", int'(valid[k]), 0);
            check_output("reset data", int'(dat[k]), 0);
            check_output("reset ferr", int'(ferr[k]), 0);
            check_output("reset busy", int'(busy[k]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed frames");
        apply_stimulus(2'd0, 'h0800); wait_idle();
        apply_stimulus(2'd0, 'h0FFF); wait_idle();
        apply_stimulus(2'd0, 'h0000); wait_idle();
        apply_stimulus(2'd1, 'h0FFF); wait_idle();
        apply_stimulus(2'd1, 'h0000); wait_idle();
        apply_stimulus(2'd0, 'h5ABC); wait_idle();
        apply_stimulus(2'd0, 'h0123); wait_idle();
        apply_stimulus(2'd2, 'h0800); wait_idle();

        $display("[TB] overrun");
        apply_stimulus(2'd0, 'h0456);
        repeat (9) @(negedge clk);
        req[0] = 1'b1;
        ovrq.push_back(cyc + 1);
        @(negedge clk);
        req[0] = 1'b0;
        wait_idle();

        $display("[TB] back-to-back");
        apply_stimulus(2'd0, 'h0A5A);
        wait_free(2'd0);
        apply_stimulus(2'd0, 'h0F0F);
        check_output("b2b csn low", int'(csn[0]), 0);
        check_output("b2b busy", int'(busy[0]), 1);
        wait_idle();

        $display("[TB] enable drop");
        adc_word[0] = 16'h0777;
        req[0] = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        req[0] = 1'b0;
        while (cyc < c0 + 29) @(negedge clk);
        en     = 1'b0;
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        check_output("en drop csn", int'(csn[0]), 1);
        check_output("en drop sck", int'(sck[0]), 1);
        check_output("en drop busy", int'(busy[0]), 0);
        check_output("en drop data held", int'(dat[0]), last_data[0]);
        repeat (3) @(negedge clk);
        check_output("disabled busy", int'(busy[0]), 0);
        req[0] = 1'b0;
        en     = 1'b1;
        @(negedge clk);
        apply_stimulus(2'd0, 'h0321);
        wait_idle();

        $display("[TB] reset mid-frame");
        adc_word[0] = 16'h0ABC;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async rst csn", int'(csn[0]), 1);
        check_output("async rst sck", int'(sck[0]), 1);
        check_output("async rst data", int'(dat[0]), 0);
        check_output("async rst busy", int'(busy[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            logic [1:0] k;
            int         word;
            k    = 2'($urandom_range(0, 2));
            word = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) word = word % 4096;
            wait_free(k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            apply_stimulus(k, word);
        end
        wait_idle();
        check_output("overrun queue empty", ovrq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
